rv32_stage_sequencer: RTL and testbench

Parametrised control sequencer for the next-generation multi-cycle RV32I core. It replaces the fixed four-stage FSM with one that handles fetch and data-memory wait states, watchdog timeouts, illegal-instruction traps, debug halt/resume and a retired-instruction counter. It drives the stage enables of the decoder, ALU, branch unit and memory controller, plus the register-file write strobe. It sits inside the core top level, beside the datapath units.

---
 rtl/rv32_stage_sequencer_pkg.sv | 32 +++
 rtl/seq_wait_timer.sv | 36 +++
 rtl/rv32_stage_sequencer.sv | 149 ++++++++++++++
 tb/tb_rv32_stage_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_stage_sequencer_pkg.sv
// Shared definitions for the RV32I multi-cycle stage sequencer.
//   stage_t      : sequencer states, 3-bit encoding
//   trap_cause_t : reason reported on trap_cause while the core is trapped
//   timer_width  : wait-counter width able to hold the larger of two limits
package rv32_stage_sequencer_pkg;

    typedef enum logic [2:0] {
        BOOT       = 3'd0,
        FETCH      = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        MEM_WAIT   = 3'd4,
        WRITE_BACK = 3'd5,
        HALT       = 3'd6,
        TRAP       = 3'd7
    } stage_t;

    typedef enum logic [1:0] {
        CAUSE_NONE          = 2'd0,
        CAUSE_ILLEGAL       = 2'd1,
        CAUSE_MEM_TIMEOUT   = 2'd2,
        CAUSE_FETCH_TIMEOUT = 2'd3
    } trap_cause_t;

    // Smallest width that can represent max(a, b); never less than 1 bit.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Saturating wait-cycle counter shared by the FETCH and MEM_WAIT stages.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : clear the count (has priority over increment)
//   i_inc        : count one more wait cycle; holds at all-ones
//   i_limit      : timeout limit; 0 disables the timeout
//   o_at_limit   : the cycle being counted now is the limit-th wait cycle
module seq_wait_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_at_limit
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_plus1;

    // One extra bit so the compare stays correct when r_count is all-ones.
    assign w_count_plus1 = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    assign o_at_limit    = (i_limit != '0) && (w_count_plus1 >= {1'b0, i_limit});

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= w_count_plus1[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/rv32_stage_sequencer.sv
// Control sequencer for the multi-cycle RV32I core.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   i_instr_valid                      : instruction memory data valid for pc
//   i_is_ebreak/i_is_mem_op/i_is_illegal : decoder flags, sampled in EXECUTE
//   i_data_read_rdy/i_data_write_rdy   : data memory completion
//   i_dbg_halt_req                     : level, halt at next instruction boundary
//   i_dbg_resume                       : pulse, leave HALT (ignored while halt_req high)
//   o_fetch_en/o_decode_en/o_execute_en : stage enables (Moore)
//   o_wb_en                            : register-file write strobe
//   o_halted/o_trapped                 : state is HALT / TRAP
//   o_trap_cause                       : 0 none, 1 illegal, 2 mem timeout, 3 fetch timeout
//   o_retired                          : retired-instruction count, wraps
module rv32_stage_sequencer #(
    parameter int unsigned RETIRE_W        = 32,
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter int unsigned FETCH_TIMEOUT   = 255,
    parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_instr_valid,
    input  logic                i_is_ebreak,
    input  logic                i_is_mem_op,
    input  logic                i_is_illegal,
    input  logic                i_data_read_rdy,
    input  logic                i_data_write_rdy,
    input  logic                i_dbg_halt_req,
    input  logic                i_dbg_resume,
    output logic                o_fetch_en,
    output logic                o_decode_en,
    output logic                o_execute_en,
    output logic                o_wb_en,
    output logic                o_halted,
    output logic                o_trapped,
    output logic [1:0]          o_trap_cause,
    output logic [RETIRE_W-1:0] o_retired
);

    import rv32_stage_sequencer_pkg::*;

    localparam int unsigned      CNT_W       = timer_width(MEM_TIMEOUT, FETCH_TIMEOUT);
    localparam logic [CNT_W-1:0] MEM_LIMIT   = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] FETCH_LIMIT = CNT_W'(FETCH_TIMEOUT);

    stage_t                r_state;
    stage_t                w_next_state;
    trap_cause_t           r_cause;
    trap_cause_t           w_next_cause;
    logic                  r_nop;        // instruction in flight is an illegal NOP
    logic [RETIRE_W-1:0]   r_retired;
    logic                  w_timeout;
    logic                  w_timer_clear;
    logic                  w_timer_inc;
    logic [CNT_W-1:0]      w_limit;

    // The counter only runs in the two waiting stages; its limit follows the stage.
    assign w_limit       = (r_state == MEM_WAIT) ? MEM_LIMIT : FETCH_LIMIT;
    assign w_timer_clear = (w_next_state != r_state);
    assign w_timer_inc   = (r_state == FETCH) || (r_state == MEM_WAIT);

    seq_wait_timer #(
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_timer_clear),
        .i_inc      (w_timer_inc),
        .i_limit    (w_limit),
        .o_at_limit (w_timeout)
    );

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        case (r_state)
            BOOT:     w_next_state = FETCH;
            FETCH: begin
                if (i_instr_valid) begin
                    w_next_state = DECODE;
                end else if (i_dbg_halt_req) begin
                    w_next_state = HALT;
                end else if (w_timeout) begin
                    w_next_state = TRAP;
                    w_next_cause = CAUSE_FETCH_TIMEOUT;
                end
            end
            DECODE:   w_next_state = EXECUTE;
            EXECUTE: begin
                if (i_is_illegal && (TRAP_ON_ILLEGAL != 0)) begin
                    w_next_state = TRAP;
                    w_next_cause = CAUSE_ILLEGAL;
                end else if (i_is_ebreak) begin
                    w_next_state = HALT;
                end else if (i_is_mem_op) begin
                    w_next_state = MEM_WAIT;
                end else begin
                    w_next_state = WRITE_BACK;
                end
            end
            MEM_WAIT: begin
                // Completion is checked first so a ready on the timeout cycle still retires.
                if (i_data_read_rdy || i_data_write_rdy) begin
                    w_next_state = WRITE_BACK;
                end else if (w_timeout) begin
                    w_next_state = TRAP;
                    w_next_cause = CAUSE_MEM_TIMEOUT;
                end
            end
            WRITE_BACK: w_next_state = i_dbg_halt_req ? HALT : FETCH;
            HALT: begin
                if (i_dbg_resume && !i_dbg_halt_req) begin
                    w_next_state = FETCH;
                end
            end
            TRAP:     w_next_state = TRAP;
            default:  w_next_state = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BOOT;
            r_cause   <= CAUSE_NONE;
            r_nop     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            r_cause <= w_next_cause;
            // Only reaches WRITE_BACK with illegal set when illegal ops are NOPs.
            if (r_state == EXECUTE) begin
                r_nop <= i_is_illegal;
            end
            if (r_state == WRITE_BACK) begin
                r_retired <= r_retired + RETIRE_W'(1);
            end
        end
    end

    assign o_fetch_en   = (r_state == FETCH);
    assign o_decode_en  = (r_state == DECODE);
    assign o_execute_en = (r_state == EXECUTE);
    assign o_wb_en      = (r_state == WRITE_BACK) && !r_nop;
    assign o_halted     = (r_state == HALT);
    assign o_trapped    = (r_state == TRAP);
    assign o_trap_cause = r_cause;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_rv32_stage_sequencer.sv
module tb_rv32_stage_sequencer;

    // Two builds run side by side on the same inputs.
    localparam int A_RW = 32, A_MT = 255, A_FT = 255, A_TI = 1;
    localparam int B_RW = 8,  B_MT = 8,   B_FT = 16,  B_TI = 0;

    typedef struct packed {
        logic iv, ebreak, mem, ill, rd, wr, halt, resume;
    } in_t;

    typedef struct packed {
        logic fetch, decode, exec, wb, halted, trapped;
        logic [1:0] cause;
    } ctl_t;

    // Behavioural model: where the instruction is, and how long it has waited there.
    localparam int PH_BOOT = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3;
    localparam int PH_MEM = 4, PH_WB = 5, PH_HALT = 6, PH_TRAP = 7;

    typedef struct {
        int     phase;
        int     waited;
        int     cause;
        longint retired;
        bit     nop;
    } model_t;

    typedef struct {
        in_t  in;
        ctl_t exp_ctl;
        int   exp_retired;
    } vec_t;

    localparam in_t IN_NONE   = 8'h00;
    localparam in_t IN_IV     = 8'h80;
    localparam in_t IN_MEM    = 8'h20;
    localparam in_t IN_ILL    = 8'h10;
    localparam in_t IN_RD     = 8'h08;
    localparam in_t IN_HALT   = 8'h02;
    localparam in_t IN_RESUME = 8'h01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  cur = '0;

    logic a_fetch, a_decode, a_exec, a_wb, a_halted, a_trapped;
    logic [1:0] a_cause;
    logic [A_RW-1:0] a_retired;
    logic b_fetch, b_decode, b_exec, b_wb, b_halted, b_trapped;
    logic [1:0] b_cause;
    logic [B_RW-1:0] b_retired;
    ctl_t a_ctl, b_ctl;

    assign a_ctl = {a_fetch, a_decode, a_exec, a_wb, a_halted, a_trapped, a_cause};
    assign b_ctl = {b_fetch, b_decode, b_exec, b_wb, b_halted, b_trapped, b_cause};

    int n_checks = 0;
    int n_fail   = 0;
    model_t m_a, m_b;
    vec_t vecs[14];

    always #5 clk = ~clk;

    rv32_stage_sequencer #(
        .RETIRE_W(A_RW), .MEM_TIMEOUT(A_MT), .FETCH_TIMEOUT(A_FT), .TRAP_ON_ILLEGAL(A_TI)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_instr_valid(cur.iv), .i_is_ebreak(cur.ebreak), .i_is_mem_op(cur.mem),
        .i_is_illegal(cur.ill), .i_data_read_rdy(cur.rd), .i_data_write_rdy(cur.wr),
        .i_dbg_halt_req(cur.halt), .i_dbg_resume(cur.resume),
        .o_fetch_en(a_fetch), .o_decode_en(a_decode), .o_execute_en(a_exec), .o_wb_en(a_wb),
        .o_halted(a_halted), .o_trapped(a_trapped), .o_trap_cause(a_cause), .o_retired(a_retired)
    );

    rv32_stage_sequencer #(
        .RETIRE_W(B_RW), .MEM_TIMEOUT(B_MT), .FETCH_TIMEOUT(B_FT), .TRAP_ON_ILLEGAL(B_TI)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_instr_valid(cur.iv), .i_is_ebreak(cur.ebreak), .i_is_mem_op(cur.mem),
        .i_is_illegal(cur.ill), .i_data_read_rdy(cur.rd), .i_data_write_rdy(cur.wr),
        .i_dbg_halt_req(cur.halt), .i_dbg_resume(cur.resume),
        .o_fetch_en(b_fetch), .o_decode_en(b_decode), .o_execute_en(b_exec), .o_wb_en(b_wb),
        .o_halted(b_halted), .o_trapped(b_trapped), .o_trap_cause(b_cause), .o_retired(b_retired)
    );

    function automatic model_t model_reset();
        model_t m;
        m.phase = PH_BOOT;
        m.waited = 0;
        m.cause = 0;
        m.retired = 0;
        m.nop = 1'b0;
        return m;
    endfunction

    function automatic model_t model_next(model_t m, int mem_to, int fetch_to, int trap_ill, in_t in);
        model_t n = m;
        n.waited = m.waited + 1;
        case (m.phase)
            PH_BOOT:   n.phase = PH_FETCH;
            PH_FETCH: begin
                if (in.iv) n.phase = PH_DECODE;
                else if (in.halt) n.phase = PH_HALT;
                else if (fetch_to != 0 && m.waited + 1 >= fetch_to) begin
                    n.phase = PH_TRAP;
                    n.cause = 3;
                end
            end
            PH_DECODE: n.phase = PH_EXEC;
            PH_EXEC: begin
                n.nop = in.ill;
                if (in.ill && trap_ill != 0) begin
                    n.phase = PH_TRAP;
                    n.cause = 1;
                end else if (in.ebreak) n.phase = PH_HALT;
                else if (in.mem) n.phase = PH_MEM;
                else n.phase = PH_WB;
            end
            PH_MEM: begin
                if (in.rd || in.wr) n.phase = PH_WB;
                else if (mem_to != 0 && m.waited + 1 >= mem_to) begin
                    n.phase = PH_TRAP;
                    n.cause = 2;
                end
            end
            PH_WB: begin
                n.retired = m.retired + 1;
                n.phase = in.halt ? PH_HALT : PH_FETCH;
            end
            PH_HALT: if (in.resume && !in.halt) n.phase = PH_FETCH;
            default: n.phase = m.phase;
        endcase
        if (n.phase != m.phase) n.waited = 0;
        return n;
    endfunction

    function automatic ctl_t model_ctl(model_t m);
        ctl_t c;
        c = '0;
        c.fetch   = (m.phase == PH_FETCH);
        c.decode  = (m.phase == PH_DECODE);
        c.exec    = (m.phase == PH_EXEC);
        c.wb      = (m.phase == PH_WB) && !m.nop;
        c.halted  = (m.phase == PH_HALT);
        c.trapped = (m.phase == PH_TRAP);
        c.cause   = 2'(m.cause);
        return c;
    endfunction

    function automatic logic [63:0] model_ret(model_t m, int rw);
        return 64'(m.retired) & ((64'd1 << rw) - 64'd1);
    endfunction

    function automatic vec_t mkv(in_t i, ctl_t c, int r);
        vec_t v;
        v.in = i;
        v.exp_ctl = c;
        v.exp_retired = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("A_ctl", 64'(a_ctl), 64'(model_ctl(m_a)));
        check("A_retired", 64'(a_retired), model_ret(m_a, A_RW));
        check("B_ctl", 64'(b_ctl), 64'(model_ctl(m_b)));
        check("B_retired", 64'(b_retired), model_ret(m_b, B_RW));
    endtask

    // Advance one clock from a falling edge to the next, stepping both models.
    task automatic tick();
        if (rst_n) begin
            m_a = model_next(m_a, A_MT, A_FT, A_TI, cur);
            m_b = model_next(m_b, B_MT, B_FT, B_TI, cur);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_A_ctl", 64'(a_ctl), 64'd0);
        check("rst_A_retired", 64'(a_retired), 64'd0);
        check("rst_B_ctl", 64'(b_ctl), 64'd0);
        check("rst_B_retired", 64'(b_retired), 64'd0);
        m_a = model_reset();
        m_b = model_reset();
        cur = IN_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    // From BOOT, fetch one instruction and stop at the start of EXECUTE.
    task automatic to_execute(input in_t decode_in);
        cur = IN_IV;
        tick();
        tick();
        cur = decode_in;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t r;
        int sel;

        m_a = model_reset();
        m_b = model_reset();

        // Vector table: three back-to-back ALU ops with instr_valid held high.
        vecs[0] = mkv(IN_IV, 8'h00, 0);
        for (int i = 1; i < 14; i++) begin
            vecs[i] = mkv((i == 13) ? IN_NONE : IN_IV, ctl_t'(8'h80 >> ((i - 1) % 4)), (i - 1) / 4);
        end

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            cur = vecs[i].in;
            check($sformatf("vec%0d_ctl", i), 64'(a_ctl), 64'(vecs[i].exp_ctl));
            check($sformatf("vec%0d_retired", i), 64'(a_retired), 64'(vecs[i].exp_retired));
            tick();
        end

        // Load, ready after 10 wait cycles on A; B (limit 8) times out meanwhile.
        cur = IN_IV;
        tick();
        cur = IN_NONE;
        tick();
        cur = IN_MEM;
        tick();
        cur = IN_NONE;
        repeat (10) tick();
        check("load_a_waiting", 64'(a_ctl), 64'h00);
        check("memto_b_trap", 64'(b_ctl), 64'h06);
        cur = IN_RD;
        tick();
        check("load_a_wb", 64'(a_ctl), 64'h10);
        cur = IN_NONE;
        tick();
        check("load_a_retired", 64'(a_retired), 64'd4);
        for (int i = 0; i < 50; i++) begin
            tick();
            check($sformatf("trap_hold%0d", i), 64'(b_ctl), 64'h06);
        end
        check("trap_b_retired", 64'(b_retired), 64'd3);
        do_reset();

        // Illegal instruction: A traps, B treats it as a NOP.
        to_execute(IN_NONE);
        cur = IN_ILL;
        tick();
        check("ill_a_trap", 64'(a_ctl), 64'h05);
        check("ill_b_nop_wb", 64'(b_ctl), 64'h00);
        cur = IN_NONE;
        tick();
        check("ill_a_retired", 64'(a_retired), 64'd0);
        check("ill_b_retired", 64'(b_retired), 64'd1);
        do_reset();

        // Halt request raised during DECODE, then resume handling.
        to_execute(IN_HALT);
        cur = IN_HALT;
        tick();
        check("halt_wb", 64'(a_ctl), 64'h10);
        tick();
        check("halt_enter", 64'(a_ctl), 64'h08);
        cur = IN_HALT | IN_RESUME;
        tick();
        check("halt_resume_ignored", 64'(a_ctl), 64'h08);
        cur = IN_NONE;
        tick();
        check("halt_hold", 64'(a_ctl), 64'h08);
        cur = IN_RESUME;
        tick();
        check("halt_resume_fetch", 64'(a_ctl), 64'h80);
        check("halt_retired", 64'(a_retired), 64'd1);
        cur = IN_NONE;
        do_reset();

        // Ready on the same cycle B reaches its memory timeout.
        to_execute(IN_NONE);
        cur = IN_MEM;
        tick();
        cur = IN_NONE;
        repeat (7) tick();
        cur = IN_RD;
        tick();
        check("rdy_at_timeout_b_wb", 64'(b_ctl), 64'h10);
        cur = IN_NONE;
        do_reset();

        // 256 instructions: B's 8-bit counter wraps 255 -> 0.
        cur = IN_IV;
        tick();
        for (int k = 0; k < 256; k++) begin
            repeat (4) tick();
            if (k == 254) check("wrap_b_255", 64'(b_retired), 64'd255);
        end
        check("wrap_b_0", 64'(b_retired), 64'd0);
        check("wrap_a_256", 64'(a_retired), 64'd256);
        cur = IN_NONE;
        do_reset();

        // Fetch timeout on B after 16 cycles without instr_valid.
        tick();
        repeat (15) tick();
        check("fetchto_b_waiting", 64'(b_ctl), 64'h80);
        tick();
        check("fetchto_b_trap", 64'(b_ctl), 64'h07);
        check("fetchto_a_fetching", 64'(a_ctl), 64'h80);
        do_reset();

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            r = '0;
            r.iv = ($urandom_range(0, 99) < 60);
            sel = int'($urandom_range(0, 99));
            if (sel < 5) r.ill = 1'b1;
            else if (sel < 10) r.ebreak = 1'b1;
            else if (sel < 40) r.mem = 1'b1;
            r.rd = ($urandom_range(0, 99) < 25);
            r.wr = ($urandom_range(0, 99) < 15);
            r.halt = ($urandom_range(0, 99) < 8);
            r.resume = ($urandom_range(0, 99) < 30);
            cur = r;
            tick();
            if ((a_trapped && b_trapped) || (c % 400 == 399)) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
